// File: rtl/intadd_arb.sv
// Round-robin arbiter and sequencer that shares a single intadd unit among NREQ requesters.
// Only one transaction is in flight at a time. The winning micro-op is latched, then issued to
// intadd for exactly one cycle. The combinational dst results are captured on the issue edge,
// and the registered status word is captured ST_LAT cycles later. The captured results are
// then held, together with the owner ID, until the response handshake completes.
module intadd_arb #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned IDW    = 2,
  parameter int unsigned ST_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*11-1:0]  req_cru,
  input  logic [NREQ*128-1:0] req_src0,
  input  logic [NREQ*128-1:0] req_src1,
  input  logic [NREQ*128-1:0] req_src2,
  output logic [10:0]         ia_cru,
  output logic [127:0]        ia_src0,
  output logic [127:0]        ia_src1,
  output logic [127:0]        ia_src2,
  input  logic [127:0]        ia_dst0,
  input  logic [127:0]        ia_dst1,
  input  logic [127:0]        ia_st,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [127:0]        rsp_dst0,
  output logic [127:0]        rsp_dst1,
  output logic [127:0]        rsp_st,
  output logic                busy
);

  localparam int unsigned CntW = (ST_LAT > 1) ? $clog2(ST_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [CntW-1:0] cnt_q;
  logic [10:0]     ia_cru_q;
  logic [127:0]    src0_q, src1_q, src2_q;
  logic [127:0]    dst0_q, dst1_q, st_q;

  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  cand;
  logic            found;
  logic [NREQ-1:0] unused_cru_msb;

  // Bit 10 of each request is replaced by a forced 1 at issue, so the incoming value is ignored.
  always_comb begin
    unused_cru_msb = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      unused_cru_msb[i] = req_cru[11*i+10];
    end
  end

  // Find the first valid requester, starting the search just after the last winner.
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // Accept is offered only in idle, and only to the single winning requester.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && found) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Sequencer FSM with all intadd-facing and response-facing state registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= IDW'(NREQ - 1);
      id_q     <= '0;
      cnt_q    <= '0;
      ia_cru_q <= '0;
      src0_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dst0_q   <= '0;
      dst1_q   <= '0;
      st_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            // inst_valid is forced high so intadd always latches status for this op.
            ia_cru_q <= {1'b1, req_cru[11*grant +: 10]};
            src0_q   <= req_src0[128*grant +: 128];
            src1_q   <= req_src1[128*grant +: 128];
            src2_q   <= req_src2[128*grant +: 128];
            id_q     <= grant;
            ptr_q    <= grant;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          dst0_q   <= ia_dst0;
          dst1_q   <= ia_dst1;
          ia_cru_q <= '0;
          cnt_q    <= CntW'(ST_LAT - 1);
          state_q  <= StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            st_q    <= ia_st;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ia_cru    = ia_cru_q;
  assign ia_src0   = src0_q;
  assign ia_src1   = src1_q;
  assign ia_src2   = src2_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = id_q;
  assign rsp_dst0  = dst0_q;
  assign rsp_dst1  = dst1_q;
  assign rsp_st    = st_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_intadd_arb.sv
// Directed bench for intadd_arb. Two instances are used: one with ST_LAT=1 for the main
// scenarios, and one with ST_LAT=3 that shares the request buses. Each instance drives a
// small intadd stand-in: lane-wise 32b add on dst0, xor on dst1, and a status word
// registered ST_LAT edges after the issue.
module tb_intadd_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [43:0]  req_cru;
  logic [511:0] req_src0, req_src1, req_src2;
  logic [10:0]  ia_cru;
  logic [127:0] ia_src0, ia_src1, ia_src2, ia_dst0, ia_dst1, ia_st;
  logic         rsp_valid, rsp_ready, busy;
  logic [1:0]   rsp_id;
  logic [127:0] rsp_dst0, rsp_dst1, rsp_st;

  logic [3:0]   b_req_valid, b_req_ready;
  logic [10:0]  b_ia_cru;
  logic [127:0] b_ia_src0, b_ia_src1, b_ia_src2, b_ia_dst0, b_ia_dst1, b_ia_st;
  logic         b_rsp_valid, b_busy;
  logic         b_rsp_ready = 1'b1;
  logic [1:0]   b_rsp_id;
  logic [127:0] b_rsp_dst0, b_rsp_dst1, b_rsp_st;
  logic [127:0] b_pipe [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [127:0] lane_add(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    for (int l = 0; l < 4; l++) r[32*l +: 32] = a[32*l +: 32] + b[32*l +: 32];
    return r;
  endfunction

  function automatic logic [127:0] st_fn(input logic [10:0] c, input logic [127:0] a,
                                         input logic [127:0] b, input logic [127:0] d);
    return a ^ b ^ d ^ {117'd0, c};
  endfunction

  assign ia_dst0   = lane_add(ia_src0, ia_src1);
  assign ia_dst1   = ia_src0 ^ ia_src2;
  assign b_ia_dst0 = lane_add(b_ia_src0, b_ia_src1);
  assign b_ia_dst1 = b_ia_src0 ^ b_ia_src2;
  assign b_ia_st   = b_pipe[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ia_st <= '0;
    else if (ia_cru[10]) ia_st <= st_fn(ia_cru, ia_src0, ia_src1, ia_src2);
  end

  // Three-stage status delay: a capture one edge early still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_pipe[0] <= '0;
      b_pipe[1] <= '0;
      b_pipe[2] <= '0;
    end else begin
      if (b_ia_cru[10]) b_pipe[0] <= st_fn(b_ia_cru, b_ia_src0, b_ia_src1, b_ia_src2);
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
    end
  end

  intadd_arb #(.NREQ(4), .IDW(2), .ST_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cru(req_cru), .req_src0(req_src0), .req_src1(req_src1), .req_src2(req_src2),
    .ia_cru(ia_cru), .ia_src0(ia_src0), .ia_src1(ia_src1), .ia_src2(ia_src2),
    .ia_dst0(ia_dst0), .ia_dst1(ia_dst1), .ia_st(ia_st),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_dst0(rsp_dst0), .rsp_dst1(rsp_dst1), .rsp_st(rsp_st), .busy(busy)
  );

  intadd_arb #(.NREQ(4), .IDW(2), .ST_LAT(3)) dut_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_cru(req_cru), .req_src0(req_src0), .req_src1(req_src1), .req_src2(req_src2),
    .ia_cru(b_ia_cru), .ia_src0(b_ia_src0), .ia_src1(b_ia_src1), .ia_src2(b_ia_src2),
    .ia_dst0(b_ia_dst0), .ia_dst1(b_ia_dst1), .ia_st(b_ia_st),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
    .rsp_dst0(b_rsp_dst0), .rsp_dst1(b_rsp_dst1), .rsp_st(b_rsp_st), .busy(b_busy)
  );

  task automatic set_req(input int i, input logic [10:0] c, input logic [127:0] a,
                         input logic [127:0] b, input logic [127:0] d);
    req_cru[11*i +: 11]   = c;
    req_src0[128*i +: 128] = a;
    req_src1[128*i +: 128] = b;
    req_src2[128*i +: 128] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; b_req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (ia_cru !== 11'd0) begin failures++; $display("FAIL rst_ia_cru got=%h exp=0", ia_cru); end
    checks++; if (ia_src0 !== 128'd0) begin failures++; $display("FAIL rst_ia_src0 got=%h exp=0", ia_src0); end
    checks++; if (rsp_st !== 128'd0) begin failures++; $display("FAIL rst_rsp_st got=%h exp=0", rsp_st); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_req_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 11'h401, {16{8'h01}}, {16{8'h02}}, {16{8'h03}});
    req_valid = 4'b0001; rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL t1_ready got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (ia_cru !== 11'h401) begin failures++; $display("FAIL t1_issue_cru got=%h exp=401", ia_cru); end
    checks++; if (ia_src1 !== {16{8'h02}}) begin failures++; $display("FAIL t1_issue_src1 got=%h", ia_src1); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", busy); end
    @(negedge clk);
    #1;
    checks++; if (ia_cru !== 11'd0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL t1_wait got cru=%h v=%b exp cru=0 v=0", ia_cru, rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL t1_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL t1_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_dst0 !== {16{8'h03}}) begin failures++; $display("FAIL t1_dst0 got=%h exp=%h", rsp_dst0, {16{8'h03}}); end
    checks++; if (rsp_dst1 !== {16{8'h02}}) begin failures++; $display("FAIL t1_dst1 got=%h exp=%h", rsp_dst1, {16{8'h02}}); end
    checks++; if (rsp_st !== 128'h401) begin failures++; $display("FAIL t1_st got=%h exp=401", rsp_st); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t1_done got v=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_cru_force();
    logic [127:0] s0, s1, e0, est;
    s0  = {32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'h00000001};
    s1  = {32'h80000000, 32'h00000001, 32'h11111111, 32'h00000002};
    e0  = {32'h00000000, 32'h00000000, 32'h23456789, 32'h00000003};
    est = {32'h00000000, 32'hFFFFFFFE, 32'h03254769, 32'h000007C2};
    @(negedge clk);
    set_req(2, 11'h3C1, s0, s1, 128'd0);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL t3_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (ia_cru !== 11'h7C1) begin failures++; $display("FAIL t3_issue_cru got=%h exp=7c1", ia_cru); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin failures++; $display("FAIL t3_rsp got v=%b id=%0d exp v=1 id=2", rsp_valid, rsp_id); end
    checks++; if (rsp_dst0 !== e0) begin failures++; $display("FAIL t3_dst0 got=%h exp=%h", rsp_dst0, e0); end
    checks++; if (rsp_dst1 !== s0) begin failures++; $display("FAIL t3_dst1 got=%h exp=%h", rsp_dst1, s0); end
    checks++; if (rsp_st !== est) begin failures++; $display("FAIL t3_st got=%h exp=%h", rsp_st, est); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Ends with requester 1 accepted and the FSM sitting in WAIT.
  task automatic test_backpressure();
    logic [127:0] est;
    int n;
    est = {{14{8'h77}}, 16'h7375};
    @(negedge clk);
    set_req(0, 11'h402, {16{8'h11}}, {16{8'h22}}, {16{8'h44}});
    set_req(1, 11'h405, {16{8'h5A}}, {16{8'h01}}, {16{8'h3C}});
    set_req(3, 11'h406, {16{8'h09}}, {16{8'h09}}, {16{8'h09}});
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL t4_ready got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b1110;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL t4_rsp_timeout got v=%b exp=1", rsp_valid); end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_dst0 !== {16{8'h33}} ||
          rsp_dst1 !== {16{8'h55}} || rsp_st !== est) begin
        failures++;
        $display("FAIL t4_hold cyc=%0d got v=%b id=%0d d0=%h d1=%h st=%h exp st=%h",
                 c, rsp_valid, rsp_id, rsp_dst0, rsp_dst1, rsp_st, est);
      end
      checks++;
      if (req_ready !== 4'b0000 || ia_cru !== 11'd0) begin
        failures++;
        $display("FAIL t4_quiet cyc=%0d got ready=%b cru=%h exp 0 0", c, req_ready, ia_cru);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL t4_next_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int n;
    #1;
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || ia_cru !== 11'd0) begin failures++; $display("FAIL t5_in_wait got busy=%b v=%b cru=%h", busy, rsp_valid, ia_cru); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'd0 || ia_cru !== 11'd0) begin failures++; $display("FAIL t5_rst_ctl got busy=%b v=%b ready=%b cru=%h exp all 0", busy, rsp_valid, req_ready, ia_cru); end
    checks++; if (ia_src0 !== 128'd0 || ia_src1 !== 128'd0 || ia_src2 !== 128'd0) begin failures++; $display("FAIL t5_rst_src got %h %h %h exp 0", ia_src0, ia_src1, ia_src2); end
    checks++; if (rsp_dst0 !== 128'd0 || rsp_dst1 !== 128'd0 || rsp_st !== 128'd0 || rsp_id !== 2'd0) begin failures++; $display("FAIL t5_rst_rsp got d0=%h d1=%h st=%h id=%0d exp 0", rsp_dst0, rsp_dst1, rsp_st, rsp_id); end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL t5_first_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    n = 0;
    #1;
    while (rsp_valid !== 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin failures++; $display("FAIL t5_rsp got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id); end
    checks++; if (rsp_dst0 !== {16{8'h5B}}) begin failures++; $display("FAIL t5_dst0 got=%h exp=%h", rsp_dst0, {16{8'h5B}}); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int gcount, last;
    logic [3:0] expv;
    do_reset();
    @(negedge clk);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    gcount = 0;
    last = 0;
    for (int cyc = 0; cyc < 40 && gcount < 6; cyc++) begin
      #1;
      checks++; if ($countones(req_ready) > 1) begin failures++; $display("FAIL t2_onehot cyc=%0d got=%b exp at most one bit", cyc, req_ready); end
      if (req_ready !== 4'b0000) begin
        expv = 4'(1 << (gcount % 4));
        checks++; if (req_ready !== expv) begin failures++; $display("FAIL t2_order n=%0d got=%b exp=%b", gcount, req_ready, expv); end
        if (gcount > 0) begin
          checks++; if (cyc - last !== 4) begin failures++; $display("FAIL t2_period n=%0d got=%0d exp=4", gcount, cyc - last); end
        end
        last = cyc;
        gcount++;
      end
      @(negedge clk);
    end
    checks++; if (gcount !== 6) begin failures++; $display("FAIL t2_grant_count got=%0d exp=6", gcount); end
    req_valid = '0;
    repeat (5) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_st_lat3();
    logic [127:0] est;
    est = {{14{8'hAA}}, 16'hAEAB};
    @(negedge clk);
    set_req(0, 11'h001, {16{8'hA5}}, {16{8'h0F}}, 128'd0);
    b_req_valid = 4'b0001;
    #1;
    checks++; if (b_req_ready !== 4'b0001) begin failures++; $display("FAIL t6_ready got=%b exp=0001", b_req_ready); end
    @(negedge clk);
    b_req_valid = '0;
    #1;
    checks++; if (b_ia_cru !== 11'h401) begin failures++; $display("FAIL t6_issue_cru got=%h exp=401", b_ia_cru); end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      #1;
      checks++; if (b_rsp_valid !== 1'b0 || b_busy !== 1'b1) begin failures++; $display("FAIL t6_wait k=%0d got v=%b busy=%b exp v=0 busy=1", k, b_rsp_valid, b_busy); end
    end
    @(negedge clk);
    #1;
    checks++; if (b_rsp_valid !== 1'b1) begin failures++; $display("FAIL t6_rsp_valid got=%b exp=1", b_rsp_valid); end
    checks++; if (b_rsp_st !== est) begin failures++; $display("FAIL t6_st got=%h exp=%h", b_rsp_st, est); end
    checks++; if (b_rsp_dst0 !== {16{8'hB4}}) begin failures++; $display("FAIL t6_dst0 got=%h exp=%h", b_rsp_dst0, {16{8'hB4}}); end
    @(negedge clk);
    #1;
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL t6_idle got busy=%b exp=0", b_busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    b_req_valid = '0;
    rsp_ready = 1'b0;
    req_cru = '0;
    req_src0 = '0;
    req_src1 = '0;
    req_src2 = '0;
    test_reset();
    test_single();
    test_cru_force();
    test_backpressure();
    test_reset_in_wait();
    test_round_robin();
    test_st_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
